axis_out_buffer: RTL

Output-side buffer for a dense layer. Collects the layer's result words over a random-access write port, then transmits all of them, in address order, as one AXI-Stream packet. The dense datapath drives the write side through its `axisif_bufferOut_adr`/`axisif_bufferOut_data` outputs. Its `putData` signal drives `start`. The AXI-Stream master side feeds the next stage or the DMA.

---
 rtl/dense_pkg.sv | 28 ++
 rtl/axis_out_buffer_loop_counter.sv | 31 +++
 rtl/axis_out_buffer.sv | 107 ++++++++++
 3 files changed

// File: rtl/dense_pkg.sv
// Shared definitions for the dense-layer buffers: FSM state encodings and
// the signed saturation helper used when narrowing accumulator words.
package dense_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_SEND = 2'd2;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    LOAD = ST_LOAD,
    SEND = ST_SEND
  } state_t;

  // Clamp a sign-extended value into the signed range of a width-bit word.
  // The caller keeps the low width bits of the result.
  function automatic logic signed [63:0] sat_signed(input logic signed [63:0] val,
                                                    input int unsigned width);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (width - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (width - 1));
    if (val > hi) return hi;
    else if (val < lo) return lo;
    else return val;
  endfunction

endpackage

// File: rtl/axis_out_buffer_loop_counter.sv
// LoopCounter: modulo-N index counter; co flags the terminal count N-1.
module LoopCounter #(
  parameter int N = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_clr,
  input  logic                 i_en,
  output logic [$clog2(N)-1:0] o_cnt,
  output logic                 co
);

  localparam int W = $clog2(N);
  localparam logic [W-1:0] LAST = W'(N - 1);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= co ? '0 : r_cnt + 1'b1;
    end
  end

  assign o_cnt = r_cnt;
  assign co    = (r_cnt == LAST);

endmodule

// File: rtl/axis_out_buffer.sv
// Dense-layer output buffer: random-access word writes, then one AXI-Stream
// packet in address order. Define AXIS_OUT_BUFFER_SAT_EN to saturate on write.
module axis_out_buffer
  import dense_pkg::*;
#(
  parameter int DEPTH     = 10,
  parameter int IN_SIZE   = 32,
  parameter int DATA_SIZE = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wrEn,
  input  logic [$clog2(DEPTH)-1:0]   wrAdr,
  input  logic signed [IN_SIZE-1:0]  wrData,
  input  logic                       start,
  output logic                       busy,
  output logic                       done,
  output logic [DATA_SIZE-1:0]       m_axis_tdata,
  output logic                       m_axis_tvalid,
  input  logic                       m_axis_tready,
  output logic                       m_axis_tlast
);

  localparam int AW = $clog2(DEPTH);

  // Handshake: a beat transfers on a rising edge where tvalid && tready.
  // tvalid is a pure decode of the registered state, so it never follows
  // tready combinationally; tdata/tlast only move on a completed beat.

  state_t               r_state;
  logic [DATA_SIZE-1:0] r_mem [DEPTH];
  logic [DATA_SIZE-1:0] r_tdata;
  logic                 r_done;

  logic [AW-1:0]        w_idx;
  logic                 w_co;
  logic                 w_hs;
  logic                 w_wr;
  logic [DATA_SIZE-1:0] w_conv;

`ifdef AXIS_OUT_BUFFER_SAT_EN
  logic signed [63:0] w_wide;
  logic signed [63:0] w_sat;
  logic               w_unused_sat_hi;
  assign w_wide          = 64'(wrData);
  assign w_sat           = sat_signed(w_wide, DATA_SIZE);
  assign w_conv          = w_sat[DATA_SIZE-1:0];
  assign w_unused_sat_hi = ^w_sat;
`else
  logic w_unused_data;
  assign w_conv        = wrData[DATA_SIZE-1:0];
  assign w_unused_data = ^wrData;
`endif

  assign w_hs = (r_state == SEND) && m_axis_tready;
  assign w_wr = (r_state == IDLE) && wrEn && (32'(wrAdr) < DEPTH);

  LoopCounter #(.N(DEPTH)) u_idx (
    .clk   (clk),
    .rst   (rst),
    .i_clr (r_state == LOAD),
    .i_en  (w_hs),
    .o_cnt (w_idx),
    .co    (w_co)
  );

  // Storage has no reset: contents survive reset and carry across packets.
  always_ff @(posedge clk) begin
    if (w_wr) r_mem[wrAdr] <= w_conv;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= IDLE;
      r_tdata <= '0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: if (start) r_state <= LOAD;
        LOAD: begin
          r_tdata <= r_mem[0];
          r_state <= SEND;
        end
        SEND: begin
          if (m_axis_tready) begin
            if (w_co) begin
              r_state <= IDLE;
              r_done  <= 1'b1;
            end else begin
              // Prefetch the next word on the handshake so beats run back to back.
              r_tdata <= r_mem[w_idx + 1'b1];
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign busy          = (r_state != IDLE);
  assign done          = r_done;
  assign m_axis_tdata  = r_tdata;
  assign m_axis_tvalid = (r_state == SEND);
  assign m_axis_tlast  = (r_state == SEND) && w_co;

endmodule
